// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbitration blocks.
// The GAP state is only reachable when UART_TX_ARB_GAP_EN is defined.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE,
        GAP
    } arb_state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 217;
    localparam int BYTE_W               = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first asserted request strictly after
// the pointer, searching cyclically. Reusable by RX-side dispatchers.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_Req,
    input  logic [ID_W-1:0]    i_Ptr,
    output logic               o_Valid,
    output logic [ID_W-1:0]    o_Idx
);

    logic [ID_W-1:0] w_Cand;

    // Walk from the farthest offset down so the nearest requester wins last.
    always_comb begin
        o_Valid = 1'b0;
        o_Idx   = '0;
        w_Cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_Cand = ID_W'((int'(i_Ptr) + k) % NUM_REQ);
            if (i_Req[w_Cand]) begin
                o_Valid = 1'b1;
                o_Idx   = w_Cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among NUM_REQ byte sources, with
// packet lock. Define UART_TX_ARB_GAP_EN to add a one-bit-time GAP after done.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int TIMEOUT_CLKS = 2604
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_L,
    input  logic [NUM_REQ-1:0]       i_Req,
    input  logic [NUM_REQ*BYTE_W-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]       i_Lock,
    output logic [NUM_REQ-1:0]       o_Ack,
    output logic [ID_W-1:0]          o_Grant_Id,
    output logic                     o_TX_DV,
    output logic [BYTE_W-1:0]        o_TX_Byte,
    input  logic                     i_TX_Done,
    output logic                     o_Busy,
    output logic                     o_Timeout
);

    localparam int WDOG_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    arb_state_t          r_State, n_State;
    logic [ID_W-1:0]     r_Ptr, n_Ptr;
    logic [ID_W-1:0]     r_Grant_Id, n_Grant_Id;
    logic [BYTE_W-1:0]   r_TX_Byte, n_TX_Byte;
    logic [NUM_REQ-1:0]  r_Ack, n_Ack;
    logic                r_TX_DV, n_TX_DV;
    logic                r_Timeout, n_Timeout;
    logic                r_Busy, n_Busy;
    logic [WDOG_W-1:0]   r_Wdog, n_Wdog;
    logic                w_Decide;
    logic                w_Lock_Hold;
    logic                w_Pick_Valid;
    logic [ID_W-1:0]     w_Pick_Idx;
    logic [BYTE_W-1:0]   w_Bytes [NUM_REQ];

`ifdef UART_TX_ARB_GAP_EN
    localparam int GAP_CLKS = CLKS_PER_BIT_DEFAULT;
    localparam int GAP_W    = $clog2(GAP_CLKS);
    logic [GAP_W-1:0]    r_Gap_Cnt, n_Gap_Cnt;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_Bytes[g] = i_Req_Byte[BYTE_W*g +: BYTE_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .i_Req   (i_Req),
        .i_Ptr   (r_Ptr),
        .o_Valid (w_Pick_Valid),
        .o_Idx   (w_Pick_Idx)
    );

    assign w_Lock_Hold = i_Lock[r_Grant_Id] & i_Req[r_Grant_Id];

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        n_State    = r_State;
        n_Ptr      = r_Ptr;
        n_Grant_Id = r_Grant_Id;
        n_TX_Byte  = r_TX_Byte;
        n_Ack      = '0;
        n_TX_DV    = 1'b0;
        n_Timeout  = 1'b0;
        n_Wdog     = r_Wdog;
        w_Decide   = 1'b0;
`ifdef UART_TX_ARB_GAP_EN
        n_Gap_Cnt  = r_Gap_Cnt;
`endif
        case (r_State)
            IDLE: begin
                if (w_Pick_Valid) begin
                    n_TX_Byte         = w_Bytes[w_Pick_Idx];
                    n_Ack[w_Pick_Idx] = 1'b1;
                    n_Ptr             = w_Pick_Idx;
                    n_Grant_Id        = w_Pick_Idx;
                    n_State           = LAUNCH;
                end
            end
            LAUNCH: begin
                n_TX_DV = 1'b1;
                n_Wdog  = '0;
                n_State = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_TX_Done) begin
`ifdef UART_TX_ARB_GAP_EN
                    n_Gap_Cnt = '0;
                    n_State   = GAP;
`else
                    w_Decide  = 1'b1;
`endif
                end else if (r_Wdog == WDOG_W'(TIMEOUT_CLKS - 1)) begin
                    n_Timeout = 1'b1;
                    n_State   = IDLE;
                end else begin
                    n_Wdog = r_Wdog + 1'b1;
                end
            end
`ifdef UART_TX_ARB_GAP_EN
            GAP: begin
                if (r_Gap_Cnt == GAP_W'(GAP_CLKS - 1)) begin
                    w_Decide = 1'b1;
                end else begin
                    n_Gap_Cnt = r_Gap_Cnt + 1'b1;
                end
            end
`endif
            default: n_State = IDLE;
        endcase

        // A locked source that still has data keeps the transmitter; the
        // pointer stays put so round-robin resumes where it left off.
        if (w_Decide) begin
            if (w_Lock_Hold) begin
                n_TX_Byte         = w_Bytes[r_Grant_Id];
                n_Ack[r_Grant_Id] = 1'b1;
                n_State           = LAUNCH;
            end else begin
                n_State = IDLE;
            end
        end

        n_Busy = (n_State != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            r_State    <= IDLE;
            r_Ptr      <= ID_W'(NUM_REQ - 1);
            r_Grant_Id <= '0;
            r_TX_Byte  <= '0;
            r_Ack      <= '0;
            r_TX_DV    <= 1'b0;
            r_Timeout  <= 1'b0;
            r_Busy     <= 1'b0;
            r_Wdog     <= '0;
`ifdef UART_TX_ARB_GAP_EN
            r_Gap_Cnt  <= '0;
`endif
        end else begin
            r_State    <= n_State;
            r_Ptr      <= n_Ptr;
            r_Grant_Id <= n_Grant_Id;
            r_TX_Byte  <= n_TX_Byte;
            r_Ack      <= n_Ack;
            r_TX_DV    <= n_TX_DV;
            r_Timeout  <= n_Timeout;
            r_Busy     <= n_Busy;
            r_Wdog     <= n_Wdog;
`ifdef UART_TX_ARB_GAP_EN
            r_Gap_Cnt  <= n_Gap_Cnt;
`endif
        end
    end

    assign o_Ack      = r_Ack;
    assign o_Grant_Id = r_Grant_Id;
    assign o_TX_DV    = r_TX_DV;
    assign o_TX_Byte  = r_TX_Byte;
    assign o_Busy     = r_Busy;
    assign o_Timeout  = r_Timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a simple UART_TX
// stand-in that returns done FRAME_CLKS cycles after each DV.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ID_W       = 2;
    localparam int TIMEOUT    = 2604;
    localparam int FRAME_CLKS = 20;
`ifdef UART_TX_ARB_GAP_EN
    localparam int GAP_EXTRA  = 217;
`else
    localparam int GAP_EXTRA  = 0;
`endif

    logic                  r_Clock;
    logic                  i_Rst_L;
    logic [NUM_REQ-1:0]    i_Req;
    logic [NUM_REQ*8-1:0]  i_Req_Byte;
    logic [NUM_REQ-1:0]    i_Lock;
    logic [NUM_REQ-1:0]    o_Ack;
    logic [ID_W-1:0]       o_Grant_Id;
    logic                  o_TX_DV;
    logic [7:0]            o_TX_Byte;
    logic                  i_TX_Done;
    logic                  o_Busy;
    logic                  o_Timeout;

    int         test_count = 0;
    int         fail_count = 0;
    int         cycle_count = 0;
    int         timeout_seen = 0;
    int         req_rise_cycle [NUM_REQ];
    logic [7:0] src_q [NUM_REQ][$];
    logic       lock_mode [NUM_REQ];
    logic [7:0] rx_q [$];
    int         dv_cycle_q [$];
    logic [ID_W-1:0] gid_q [$];
    logic       done_enable = 1'b1;
    logic       tx_busy = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .ID_W         (ID_W),
        .TIMEOUT_CLKS (TIMEOUT)
    ) dut (
        .i_Clock    (r_Clock),
        .i_Rst_L    (i_Rst_L),
        .i_Req      (i_Req),
        .i_Req_Byte (i_Req_Byte),
        .i_Lock     (i_Lock),
        .o_Ack      (o_Ack),
        .o_Grant_Id (o_Grant_Id),
        .o_TX_DV    (o_TX_DV),
        .o_TX_Byte  (o_TX_Byte),
        .i_TX_Done  (i_TX_Done),
        .o_Busy     (o_Busy),
        .o_Timeout  (o_Timeout)
    );

    initial r_Clock = 1'b0;
    always #5 r_Clock = ~r_Clock;

    always @(posedge r_Clock) cycle_count <= cycle_count + 1;
    always @(negedge r_Clock) if (o_Timeout) timeout_seen <= timeout_seen + 1;

    // Byte sources: pop on ack, keep presenting the queue head while non-empty.
    initial begin
        i_Req      = '0;
        i_Req_Byte = '0;
        i_Lock     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            lock_mode[k]      = 1'b0;
            req_rise_cycle[k] = 0;
        end
        forever begin
            @(negedge r_Clock);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (o_Ack[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (src_q[k].size() > 0 && !i_Req[k]) req_rise_cycle[k] = cycle_count;
                i_Req[k]            = (src_q[k].size() > 0);
                i_Req_Byte[8*k +: 8] = (src_q[k].size() > 0) ? src_q[k][0] : 8'h00;
                i_Lock[k]           = lock_mode[k];
            end
        end
    end

    // Transmitter stand-in: records each launched byte and answers with done.
    initial begin
        i_TX_Done = 1'b0;
        forever begin
            @(negedge r_Clock);
            if (o_TX_DV) begin
                rx_q.push_back(o_TX_Byte);
                dv_cycle_q.push_back(cycle_count);
                gid_q.push_back(o_Grant_Id);
                if (done_enable) begin
                    tx_busy = 1'b1;
                    repeat (FRAME_CLKS - 1) @(negedge r_Clock);
                    i_TX_Done = 1'b1;
                    @(negedge r_Clock);
                    i_TX_Done = 1'b0;
                    tx_busy   = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int src, input logic [7:0] data);
        src_q[src].push_back(data);
    endtask

    task automatic clearLog();
        rx_q.delete();
        dv_cycle_q.delete();
        gid_q.delete();
    endtask

    task automatic waitDrain(input string tag, input int max_cycles);
        int quiet;
        logic drained;
        quiet   = 0;
        drained = 1'b0;
        for (int i = 0; i < max_cycles && !drained; i++) begin
            @(negedge r_Clock);
            if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
                src_q[3].size() == 0 && !o_Busy && !tx_busy && i_Req == '0)
                quiet++;
            else
                quiet = 0;
            if (quiet >= 3) drained = 1'b1;
        end
        checkOutput(tag, 32'(drained), 32'd1);
    endtask

    task automatic checkByte(input string tag, input int idx, input logic [7:0] expected);
        checkOutput(tag, (idx < rx_q.size()) ? 32'(rx_q[idx]) : 32'hFFFF_FFFF, 32'(expected));
    endtask

    initial begin
        logic found;
        int   t_cycle;

        i_Rst_L = 1'b0;
        repeat (3) @(negedge r_Clock);
        checkOutput("reset_outputs", 32'({o_Ack, o_Grant_Id, o_TX_DV, o_TX_Byte, o_Busy, o_Timeout}), 32'd0);
        i_Rst_L = 1'b1;
        @(posedge r_Clock); #2;

        // Contention from reset: pointer starts at NUM_REQ-1 so source 0 leads.
        clearLog();
        applyStimulus(0, 8'h10); applyStimulus(1, 8'h20);
        applyStimulus(2, 8'h30); applyStimulus(3, 8'h40);
        waitDrain("drain_round1", 500);
        checkByte("round1_b0", 0, 8'h10);
        checkByte("round1_b1", 1, 8'h20);
        checkByte("round1_b2", 2, 8'h30);
        checkByte("round1_b3", 3, 8'h40);
        checkOutput("round1_spacing", (dv_cycle_q.size() > 1) ? 32'(dv_cycle_q[1] - dv_cycle_q[0]) : 32'd0,
                    32'(FRAME_CLKS + 2 + GAP_EXTRA));

        // Single source, two bytes back to back.
        clearLog();
        @(posedge r_Clock); #2;
        applyStimulus(0, 8'h3F);
        applyStimulus(0, 8'hA5);
        waitDrain("drain_single", 500);
        checkOutput("single_latency", (dv_cycle_q.size() > 0) ? 32'(dv_cycle_q[0] - req_rise_cycle[0]) : 32'd0, 32'd2);
        checkByte("single_b0", 0, 8'h3F);
        checkByte("single_b1", 1, 8'hA5);
        checkOutput("single_no_timeout", 32'(timeout_seen), 32'd0);

        // Second round with pointer at source 0.
        clearLog();
        applyStimulus(0, 8'h10); applyStimulus(1, 8'h20);
        applyStimulus(2, 8'h30); applyStimulus(3, 8'h40);
        waitDrain("drain_round2", 500);
        checkByte("round2_b0", 0, 8'h20);
        checkByte("round2_b1", 1, 8'h30);
        checkByte("round2_b2", 2, 8'h40);
        checkByte("round2_b3", 3, 8'h10);

        // Move pointer to source 1, then a locked 3-byte packet from source 2.
        applyStimulus(1, 8'h11);
        waitDrain("drain_ptr1", 500);
        clearLog();
        lock_mode[2] = 1'b1;
        applyStimulus(2, 8'hC1); applyStimulus(2, 8'hC2); applyStimulus(2, 8'hC3);
        applyStimulus(1, 8'h55);
        waitDrain("drain_lock", 2000);
        lock_mode[2] = 1'b0;
        checkByte("lock_b0", 0, 8'hC1);
        checkByte("lock_b1", 1, 8'hC2);
        checkByte("lock_b2", 2, 8'hC3);
        checkByte("lock_b3", 3, 8'h55);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("lock_gid%0d", i), (i < gid_q.size()) ? 32'(gid_q[i]) : 32'hFF, 32'd2);
        checkOutput("lock_spacing", (dv_cycle_q.size() > 1) ? 32'(dv_cycle_q[1] - dv_cycle_q[0]) : 32'd0,
                    32'(FRAME_CLKS + 1 + GAP_EXTRA));
        checkOutput("lock_no_timeout", 32'(timeout_seen), 32'd0);

        // Watchdog: transmitter never answers.
        clearLog();
        done_enable = 1'b0;
        applyStimulus(3, 8'h99);
        found   = 1'b0;
        t_cycle = 0;
        for (int i = 0; i < TIMEOUT + 200 && !found; i++) begin
            @(negedge r_Clock);
            if (o_Timeout) begin
                found   = 1'b1;
                t_cycle = cycle_count;
            end
        end
        checkOutput("wdog_fired", 32'(found), 32'd1);
        checkOutput("wdog_delay", (dv_cycle_q.size() > 0) ? 32'(t_cycle - dv_cycle_q[0]) : 32'd0, 32'(TIMEOUT));
        @(negedge r_Clock);
        checkOutput("wdog_busy_after", 32'(o_Busy), 32'd0);
        checkOutput("wdog_pulse_width", 32'(o_Timeout), 32'd0);
        done_enable = 1'b1;
        waitDrain("drain_wdog", 100);

        // Reset during WAIT_DONE; pointer must return to NUM_REQ-1.
        clearLog();
        applyStimulus(1, 8'h5A);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge r_Clock);
            if (o_TX_DV) found = 1'b1;
        end
        checkOutput("rst_first_dv", 32'(found), 32'd1);
        repeat (5) @(negedge r_Clock);
        i_Rst_L = 1'b0;
        @(negedge r_Clock);
        checkOutput("rst_mid_outputs", 32'({o_Ack, o_Grant_Id, o_TX_DV, o_TX_Byte, o_Busy, o_Timeout}), 32'd0);
        i_Rst_L = 1'b1;
        repeat (40) @(negedge r_Clock);
        checkOutput("rst_no_resend", 32'(rx_q.size()), 32'd1);
        checkOutput("rst_idle", 32'(o_Busy), 32'd0);
        @(posedge r_Clock); #2;
        applyStimulus(3, 8'h33);
        applyStimulus(0, 8'h0A);
        waitDrain("drain_rst", 500);
        checkByte("rst_after_b0", 1, 8'h0A);
        checkByte("rst_after_b1", 2, 8'h33);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
